// File: rtl/core_pkg.sv
// Shared core types for the writeback path: register/data widths, writeback
// source encoding and the generic writeback request bundle.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register-file write port and
// the decode-stage forwarding taps.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) ();

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  logic              wb_stall;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_destn_reg;
  logic [DATA_W-1:0] rf_destn_data;
  logic              wb_done;
  logic              wb_src;

  logic [ADDR_W-1:0] rd_reg_A;
  logic [ADDR_W-1:0] rd_reg_B;
  logic              fwd_A;
  logic              fwd_B;
  logic [DATA_W-1:0] fwd_data;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  wb_stall, rd_reg_A, rd_reg_B,
    output alu_ready, mem_ready,
    output rf_wr_en, rf_destn_reg, rf_destn_data, wb_done, wb_src,
    output fwd_A, fwd_B, fwd_data
  );

  // Requester / register-file / decode side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output wb_stall, rd_reg_A, rd_reg_B,
    input  alu_ready, mem_ready,
    input  rf_wr_en, rf_destn_reg, rf_destn_data, wb_done, wb_src,
    input  fwd_A, fwd_B, fwd_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the ALU, bit 1 the load unit;
// the grant is one-hot and every grant is a completed handshake.
module rr_arb2
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  wb_src_e last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == WB_MEM) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Priority only moves on a real grant, so an idle or stalled cycle keeps it.
  always_comb begin
    last_d = last_q;
    if (gnt_o[0])      last_d = WB_ALU;
    else if (gnt_o[1]) last_d = WB_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= WB_MEM;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and the load unit, with
// one registered stage driving the write and forwarding of the write in flight.
module regfile_wb_arbiter
  import core_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb
);

  logic [1:0]        gnt;
  logic              hs;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              wr_en_q, wr_en_d;
  logic              done_q,  done_d;
  wb_src_e           src_q,   src_d;
  logic [ADDR_W-1:0] rd_q,    rd_d;
  logic [DATA_W-1:0] data_q,  data_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (!wb.wb_stall),
    .req_i ({wb.mem_valid, wb.alu_valid}),
    .gnt_o (gnt)
  );

  assign wb.alu_ready = gnt[0];
  assign wb.mem_ready = gnt[1];
  assign hs           = |gnt;
  assign sel_rd       = gnt[1] ? wb.mem_rd   : wb.alu_rd;
  assign sel_data     = gnt[1] ? wb.mem_data : wb.alu_data;

  // Writes to x0 retire normally but never raise the write enable.
  always_comb begin
    wr_en_d = hs && (sel_rd != '0);
    done_d  = hs;
    src_d   = src_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (hs) begin
      src_d  = gnt[1] ? WB_MEM : WB_ALU;
      rd_d   = sel_rd;
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= WB_ALU;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      src_q   <= src_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign wb.rf_wr_en      = wr_en_q;
  assign wb.rf_destn_reg  = rd_q;
  assign wb.rf_destn_data = data_q;
  assign wb.wb_done       = done_q;
  assign wb.wb_src        = src_q;

  // The write enable already excludes x0 and an empty stage.
  assign wb.fwd_A    = wr_en_q && (rd_q == wb.rd_reg_A);
  assign wb.fwd_B    = wr_en_q && (rd_q == wb.rd_reg_B);
  assign wb.fwd_data = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run, all
// compared against a behavioural model of arbitration, staging and the reg file.
module tb_regfile_wb_arbiter;
  import core_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Register file fed by the DUT write port
  logic [DW-1:0] dut_rf [32] = '{default: '0};
  always @(posedge clk) if (bus.rf_wr_en) dut_rf[bus.rf_destn_reg] <= bus.rf_destn_data;

  // Reference model
  logic          m_last_mem;
  logic          m_wr, m_done, m_src;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rf [32] = '{default: '0};

  function automatic logic exp_alu_rdy();
    return !bus.wb_stall && bus.alu_valid && (!bus.mem_valid || m_last_mem);
  endfunction

  function automatic logic exp_mem_rdy();
    return !bus.wb_stall && bus.mem_valid && (!bus.alu_valid || !m_last_mem);
  endfunction

  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic st, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
    bus.wb_stall = st;  bus.rd_reg_A = ra; bus.rd_reg_B = rb;
  endtask

  task automatic model_reset();
    m_last_mem = 1'b1;
    m_wr = 1'b0; m_done = 1'b0; m_src = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic tick();
    logic ga, gm;
    ga = exp_alu_rdy();
    gm = exp_mem_rdy();
    @(posedge clk);
    if (m_wr) m_rf[m_rd] = m_data;
    m_done = ga | gm;
    if (ga | gm) begin
      m_src      = gm;
      m_rd       = gm ? bus.mem_rd : bus.alu_rd;
      m_data     = gm ? bus.mem_data : bus.alu_data;
      m_last_mem = gm;
    end
    m_wr = (ga | gm) && (m_rd != '0);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tot_cnt++; if (bus.rf_wr_en !== 1'b0) $display("FAIL reset_wr_en c%0d: got %b want 0", c, bus.rf_wr_en); else pass_cnt++;
      tot_cnt++; if (bus.wb_done !== 1'b0) $display("FAIL reset_done c%0d: got %b want 0", c, bus.wb_done); else pass_cnt++;
      tot_cnt++; if ({bus.fwd_A, bus.fwd_B} !== 2'b00) $display("FAIL reset_fwd c%0d: got %b want 00", c, {bus.fwd_A, bus.fwd_B}); else pass_cnt++;
    end
    tot_cnt++; if (bus.rf_destn_reg !== '0) $display("FAIL reset_destn_reg: got %0d want 0", bus.rf_destn_reg); else pass_cnt++;
    tot_cnt++; if (bus.rf_destn_data !== '0) $display("FAIL reset_destn_data: got %h want 0", bus.rf_destn_data); else pass_cnt++;
    tot_cnt++; if (bus.wb_src !== 1'b0) $display("FAIL reset_src: got %b want 0", bus.wb_src); else pass_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      tot_cnt++; if ({bus.rf_wr_en, bus.wb_done, bus.alu_ready, bus.mem_ready} !== 4'b0000)
        $display("FAIL idle_outputs c%0d: got %b want 0000", c, {bus.rf_wr_en, bus.wb_done, bus.alu_ready, bus.mem_ready}); else pass_cnt++;
    end
  endtask

  task automatic test_single_alu();
    drive(1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    #1;
    tot_cnt++; if ({bus.alu_ready, bus.mem_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {bus.alu_ready, bus.mem_ready}); else pass_cnt++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tot_cnt++; if ({bus.rf_wr_en, bus.wb_done, bus.wb_src} !== 3'b110) $display("FAIL single_ctrl: got %b want 110", {bus.rf_wr_en, bus.wb_done, bus.wb_src}); else pass_cnt++;
    tot_cnt++; if (bus.rf_destn_reg !== 5'd5) $display("FAIL single_reg: got %0d want 5", bus.rf_destn_reg); else pass_cnt++;
    tot_cnt++; if (bus.rf_destn_data !== 64'hDEAD_BEEF) $display("FAIL single_data: got %h want deadbeef", bus.rf_destn_data); else pass_cnt++;
    tick();
    tot_cnt++; if ({bus.rf_wr_en, bus.wb_done} !== 2'b00) $display("FAIL single_retired: got %b want 00", {bus.rf_wr_en, bus.wb_done}); else pass_cnt++;
    tot_cnt++; if (bus.rf_destn_reg !== 5'd5) $display("FAIL single_hold_reg: got %0d want 5", bus.rf_destn_reg); else pass_cnt++;
    tot_cnt++; if (dut_rf[5] !== 64'hDEAD_BEEF) $display("FAIL single_readback: got %h want deadbeef", dut_rf[5]); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic exp_mem [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    drive(1, 1, 64'h111, 1, 2, 64'h222, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      tot_cnt++; if ({bus.alu_ready, bus.mem_ready} !== {!exp_mem[k], exp_mem[k]})
        $display("FAIL rr_grant k%0d: got %b want %b", k, {bus.alu_ready, bus.mem_ready}, {!exp_mem[k], exp_mem[k]}); else pass_cnt++;
      tick();
      tot_cnt++; if (bus.rf_destn_reg !== (exp_mem[k] ? 5'd2 : 5'd1))
        $display("FAIL rr_destn k%0d: got %0d want %0d", k, bus.rf_destn_reg, exp_mem[k] ? 2 : 1); else pass_cnt++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_x0();
    drive(0, 0, 0, 1, 0, 64'h1234, 0, 0, 0);
    #1;
    tot_cnt++; if ({bus.alu_ready, bus.mem_ready} !== 2'b01) $display("FAIL x0_ready: got %b want 01", {bus.alu_ready, bus.mem_ready}); else pass_cnt++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tot_cnt++; if ({bus.wb_done, bus.wb_src, bus.rf_wr_en} !== 3'b110) $display("FAIL x0_ctrl: got %b want 110", {bus.wb_done, bus.wb_src, bus.rf_wr_en}); else pass_cnt++;
    tot_cnt++; if (bus.fwd_A !== 1'b0) $display("FAIL x0_fwd: got %b want 0", bus.fwd_A); else pass_cnt++;
    tick();
    tot_cnt++; if (dut_rf[0] !== '0) $display("FAIL x0_readback: got %h want 0", dut_rf[0]); else pass_cnt++;
  endtask

  task automatic test_forward();
    drive(1, 7, 64'hA5, 0, 0, 0, 0, 7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
    #1;
    tot_cnt++; if ({bus.fwd_A, bus.fwd_B} !== 2'b10) $display("FAIL fwd_AB: got %b want 10", {bus.fwd_A, bus.fwd_B}); else pass_cnt++;
    tot_cnt++; if (bus.fwd_data !== 64'hA5) $display("FAIL fwd_data: got %h want a5", bus.fwd_data); else pass_cnt++;
    bus.rd_reg_B = 7;
    #1;
    tot_cnt++; if (bus.fwd_B !== 1'b1) $display("FAIL fwd_B_both: got %b want 1", bus.fwd_B); else pass_cnt++;
    tick();
    tot_cnt++; if ({bus.fwd_A, bus.fwd_B} !== 2'b00) $display("FAIL fwd_retired: got %b want 00", {bus.fwd_A, bus.fwd_B}); else pass_cnt++;
  endtask

  task automatic test_stall_reset();
    do_reset();
    drive(1, 3, 64'h33, 1, 4, 64'h44, 1, 0, 0);
    #1;
    tot_cnt++; if ({bus.alu_ready, bus.mem_ready} !== 2'b00) $display("FAIL stall_ready: got %b want 00", {bus.alu_ready, bus.mem_ready}); else pass_cnt++;
    tick();
    tot_cnt++; if ({bus.rf_wr_en, bus.wb_done} !== 2'b00) $display("FAIL stall_empty: got %b want 00", {bus.rf_wr_en, bus.wb_done}); else pass_cnt++;
    bus.wb_stall = 1'b0;
    #1;
    tot_cnt++; if ({bus.alu_ready, bus.mem_ready} !== 2'b10) $display("FAIL unstall_grant: got %b want 10", {bus.alu_ready, bus.mem_ready}); else pass_cnt++;
    tick();
    tot_cnt++; if (bus.rf_wr_en !== 1'b1) $display("FAIL midflight_wr_en: got %b want 1", bus.rf_wr_en); else pass_cnt++;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    tot_cnt++; if ({bus.rf_wr_en, bus.wb_done} !== 2'b00) $display("FAIL async_drop: got %b want 00", {bus.rf_wr_en, bus.wb_done}); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    tot_cnt++; if ({bus.alu_ready, bus.mem_ready} !== 2'b10) $display("FAIL post_reset_tie: got %b want 10", {bus.alu_ready, bus.mem_ready}); else pass_cnt++;
    tick();
    tot_cnt++; if ({bus.wb_src, bus.rf_destn_reg} !== {1'b0, 5'd3}) $display("FAIL post_reset_stage: got %b/%0d want 0/3", bus.wb_src, bus.rf_destn_reg); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic          av = 0, mv = 0, ga, gm, st;
    logic [AW-1:0] ard = 0, mrd = 0, ra, rb;
    logic [DW-1:0] ad = 0, md = 0;
    int            errs = 0;
    for (int c = 0; c < 400; c++) begin
      if (!av && ($urandom_range(0, 2) != 0)) begin av = 1; ard = AW'($urandom_range(0, 7)); ad = {$urandom, $urandom}; end
      if (!mv && ($urandom_range(0, 2) != 0)) begin mv = 1; mrd = AW'($urandom_range(0, 7)); md = {$urandom, $urandom}; end
      st = ($urandom_range(0, 4) == 0);
      ra = AW'($urandom_range(0, 7));
      rb = AW'($urandom_range(0, 7));
      drive(av, ard, ad, mv, mrd, md, st, ra, rb);
      #1;
      ga = exp_alu_rdy();
      gm = exp_mem_rdy();
      tot_cnt++;
      if ({bus.alu_ready, bus.mem_ready} !== {ga, gm}) begin
        if (errs++ < 10) $display("FAIL rand_ready c%0d: got %b want %b", c, {bus.alu_ready, bus.mem_ready}, {ga, gm});
      end else pass_cnt++;
      tot_cnt++;
      if ({bus.rf_wr_en, bus.wb_done, bus.wb_src, bus.rf_destn_reg, bus.rf_destn_data} !== {m_wr, m_done, m_src, m_rd, m_data}) begin
        if (errs++ < 10) $display("FAIL rand_stage c%0d: got %b%b%b/%0d/%h want %b%b%b/%0d/%h", c,
          bus.rf_wr_en, bus.wb_done, bus.wb_src, bus.rf_destn_reg, bus.rf_destn_data, m_wr, m_done, m_src, m_rd, m_data);
      end else pass_cnt++;
      tot_cnt++;
      if ({bus.fwd_A, bus.fwd_B} !== {m_wr && (m_rd == ra), m_wr && (m_rd == rb)}) begin
        if (errs++ < 10) $display("FAIL rand_fwd c%0d: got %b want %b", c, {bus.fwd_A, bus.fwd_B}, {m_wr && (m_rd == ra), m_wr && (m_rd == rb)});
      end else pass_cnt++;
      tick();
      if (ga) av = 0;
      if (gm) mv = 0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int r = 0; r < 32; r++) begin
      tot_cnt++;
      if (dut_rf[r] !== m_rf[r]) $display("FAIL rand_rf x%0d: got %h want %h", r, dut_rf[r], m_rf[r]);
      else pass_cnt++;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_single_alu();
    test_contention();
    test_x0();
    test_forward();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
